// File: rtl/mac_window_accumulator.sv
// Window accumulator: sums LEN valid samples from the multiply-add stream, tracks the
// window peak, and hands the result downstream through a one-entry valid/ready slot.
module mac_window_accumulator #(
    parameter int S   = 8,
    parameter int LEN = 4,
    localparam int ACC_W = 2*S + $clog2(LEN),
    localparam int CNT_W = $clog2(LEN) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             din_valid,
    input  logic [2*S-1:0]   din,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] sum_out,
    output logic [2*S-1:0]   peak_out,
    output logic             overrun,
    output logic [CNT_W-1:0] fill_cnt
);

    // Handshake: a result transfers on any edge where out_valid=1 and out_ready=1.
    // out_valid is the registered slot state and never looks at out_ready combinationally.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

    slot_e            slot_q;
    logic [ACC_W-1:0] acc_q;
    logic [2*S-1:0]   peak_q;
    logic [CNT_W-1:0] fill_q;
    logic [ACC_W-1:0] sum_q;
    logic [2*S-1:0]   peak_out_q;
    logic             overrun_q;

    logic [ACC_W-1:0] acc_d;
    logic [2*S-1:0]   peak_d;
    logic             complete;

    always_comb begin
        acc_d    = acc_q + ACC_W'(din);
        peak_d   = peak_q;
        // The first sample of a window loads the peak outright.
        if ((fill_q == '0) || (din > peak_q)) begin
            peak_d = din;
        end
        complete = din_valid && (fill_q == CNT_W'(LEN - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q     <= SLOT_EMPTY;
            acc_q      <= '0;
            peak_q     <= '0;
            fill_q     <= '0;
            sum_q      <= '0;
            peak_out_q <= '0;
            overrun_q  <= 1'b0;
        end else if (clear) begin
            slot_q     <= SLOT_EMPTY;
            acc_q      <= '0;
            peak_q     <= '0;
            fill_q     <= '0;
            sum_q      <= '0;
            peak_out_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            if (complete) begin
                acc_q  <= '0;
                peak_q <= '0;
                fill_q <= '0;
            end else if (din_valid) begin
                acc_q  <= acc_d;
                peak_q <= peak_d;
                fill_q <= fill_q + CNT_W'(1);
            end

            case (slot_q)
                SLOT_EMPTY: begin
                    if (complete) begin
                        sum_q      <= acc_d;
                        peak_out_q <= peak_d;
                        slot_q     <= SLOT_FULL;
                    end
                end
                SLOT_FULL: begin
                    if (complete && out_ready) begin
                        sum_q      <= acc_d;
                        peak_out_q <= peak_d;
                    end else if (complete) begin
                        // Downstream stalled: keep the older result, flag the loss.
                        overrun_q <= 1'b1;
                    end else if (out_ready) begin
                        slot_q <= SLOT_EMPTY;
                    end
                end
                default: slot_q <= SLOT_EMPTY;
            endcase
        end
    end

    assign out_valid = (slot_q == SLOT_FULL);
    assign sum_out   = sum_q;
    assign peak_out  = peak_out_q;
    assign overrun   = overrun_q;
    assign fill_cnt  = fill_q;

endmodule

// File: tb/tb_mac_window_accumulator.sv
// Bench for mac_window_accumulator: directed vector table, asynchronous reset
// sequence, then randomized traffic against a queue-based window model.
module tb_mac_window_accumulator;

    localparam int S     = 8;
    localparam int LEN   = 4;
    localparam int ACC_W = 2*S + $clog2(LEN);
    localparam int CNT_W = $clog2(LEN) + 1;

    logic             clk;
    logic             reset;
    logic             clear;
    logic             din_valid;
    logic [2*S-1:0]   din;
    logic             out_ready;
    logic             out_valid;
    logic [ACC_W-1:0] sum_out;
    logic [2*S-1:0]   peak_out;
    logic             overrun;
    logic [CNT_W-1:0] fill_cnt;

    int checks = 0;
    int errors = 0;

    mac_window_accumulator #(.S(S), .LEN(LEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .din_valid (din_valid),
        .din       (din),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .sum_out   (sum_out),
        .peak_out  (peak_out),
        .overrun   (overrun),
        .fill_cnt  (fill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic           clr;
        logic           v;
        logic [2*S-1:0] d;
        logic           rdy;
        logic           ov;
        int unsigned    sum;
        int unsigned    pk;
        logic           ovr;
        int unsigned    fill;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic ov, input int unsigned sum,
                               input int unsigned pk, input logic ovr, input int unsigned fill);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".overrun"}, 32'(overrun), 32'(ovr));
        chk({tag, ".fill_cnt"}, 32'(fill_cnt), fill);
        if (ov) begin
            chk({tag, ".sum_out"}, 32'(sum_out), sum);
            chk({tag, ".peak_out"}, 32'(peak_out), pk);
        end
    endtask

    task automatic add(input logic clr, input logic v, input int unsigned d, input logic rdy,
                       input logic ov, input int unsigned sum, input int unsigned pk,
                       input logic ovr, input int unsigned fill);
        vec_t e;
        e.clr = clr; e.v = v; e.d = (2*S)'(d); e.rdy = rdy;
        e.ov = ov; e.sum = sum; e.pk = pk; e.ovr = ovr; e.fill = fill;
        vecs.push_back(e);
    endtask

    // Inputs are driven just after an edge; outputs are sampled 1ns after the next edge.
    task automatic step(input logic clr, input logic v, input logic [2*S-1:0] d, input logic rdy);
        clear = clr; din_valid = v; din = d; out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Reference model: the current partial window as a queue of samples plus the output slot.
    int unsigned win_q[$];
    bit          m_ov;
    int unsigned m_sum, m_pk;
    bit          m_ovr;

    task automatic model_reset();
        win_q.delete();
        m_ov = 0; m_sum = 0; m_pk = 0; m_ovr = 0;
    endtask

    task automatic model_step(input bit clr, input bit v, input int unsigned d, input bit rdy);
        bit done;
        int unsigned s, p;
        done = 0; s = 0; p = 0;
        if (clr) begin
            model_reset();
            return;
        end
        if (v) begin
            win_q.push_back(d);
            if (win_q.size() == LEN) begin
                done = 1;
                foreach (win_q[k]) begin
                    s += win_q[k];
                    if (win_q[k] > p) p = win_q[k];
                end
                win_q.delete();
            end
        end
        if (!m_ov) begin
            if (done) begin m_ov = 1; m_sum = s; m_pk = p; end
        end else if (done) begin
            if (rdy) begin m_sum = s; m_pk = p; end
            else m_ovr = 1;
        end else if (rdy) begin
            m_ov = 0;
        end
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; din_valid = 1'b0; din = '0; out_ready = 1'b0;

        // Basic window 10,20,30,40 with downstream always ready.
        add(0,1,10,1,    0,0,0,0,1);
        add(0,1,20,1,    0,0,0,0,2);
        add(0,1,30,1,    0,0,0,0,3);
        add(0,1,40,1,    1,100,40,0,0);
        add(0,0,0,1,     0,0,0,0,0);
        // Full-scale samples: 4 x 65025 needs all 18 bits.
        add(0,1,65025,1, 0,0,0,0,1);
        add(0,1,65025,1, 0,0,0,0,2);
        add(0,1,65025,1, 0,0,0,0,3);
        add(0,1,65025,1, 1,260100,65025,0,0);
        // Gapped window 5,_,7,_,_,1,3 then back-to-back 2,2,2,2.
        add(0,1,5,1,     0,0,0,0,1);
        add(0,0,0,1,     0,0,0,0,1);
        add(0,1,7,1,     0,0,0,0,2);
        add(0,0,0,1,     0,0,0,0,2);
        add(0,0,0,1,     0,0,0,0,2);
        add(0,1,1,1,     0,0,0,0,3);
        add(0,1,3,1,     1,16,7,0,0);
        add(0,1,2,1,     0,0,0,0,1);
        add(0,1,2,1,     0,0,0,0,2);
        add(0,1,2,1,     0,0,0,0,3);
        add(0,1,2,1,     1,8,2,0,0);
        add(0,0,0,1,     0,0,0,0,0);
        // Backpressure: second window is dropped, overrun becomes sticky.
        add(0,1,1,0,     0,0,0,0,1);
        add(0,1,1,0,     0,0,0,0,2);
        add(0,1,1,0,     0,0,0,0,3);
        add(0,1,1,0,     1,4,1,0,0);
        add(0,1,9,0,     1,4,1,0,1);
        add(0,1,9,0,     1,4,1,0,2);
        add(0,1,9,0,     1,4,1,0,3);
        add(0,1,9,0,     1,4,1,1,0);
        add(0,0,0,1,     0,0,0,1,0);
        add(0,0,0,0,     0,0,0,1,0);
        add(1,1,9,1,     0,0,0,0,0);
        // Accept and complete on the same edge: no bubble, no drop.
        add(0,1,1,0,     0,0,0,0,1);
        add(0,1,1,0,     0,0,0,0,2);
        add(0,1,1,0,     0,0,0,0,3);
        add(0,1,1,0,     1,4,1,0,0);
        add(0,1,9,0,     1,4,1,0,1);
        add(0,1,9,0,     1,4,1,0,2);
        add(0,1,9,0,     1,4,1,0,3);
        add(0,1,9,1,     1,36,9,0,0);
        // Clear mid-window discards the partial window and the sample presented with it.
        add(0,1,3,1,     0,0,0,0,1);
        add(0,1,4,1,     0,0,0,0,2);
        add(1,1,5,1,     0,0,0,0,0);
        add(0,1,1,1,     0,0,0,0,1);
        add(0,1,1,1,     0,0,0,0,2);
        add(0,1,1,1,     0,0,0,0,3);
        add(0,1,1,0,     1,4,1,0,0);

        #12;
        chk_outputs("reset", 0, 0, 0, 0, 0);
        chk("reset.sum_out", 32'(sum_out), 0);
        chk("reset.peak_out", 32'(peak_out), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            step(vecs[i].clr, vecs[i].v, vecs[i].d, vecs[i].rdy);
            chk_outputs($sformatf("vec%0d", i), vecs[i].ov, vecs[i].sum, vecs[i].pk,
                        vecs[i].ovr, vecs[i].fill);
        end

        // Asynchronous reset mid-window with a held result and a flagged overrun.
        step(0, 1, 16'd3, 0);
        step(0, 1, 16'd4, 0);
        step(0, 1, 16'd5, 0);
        step(0, 1, 16'd6, 0);
        chk_outputs("pre_areset", 1, 4, 1, 1, 0);
        step(0, 1, 16'd7, 0);
        step(0, 1, 16'd8, 0);
        chk("pre_areset.fill_cnt", 32'(fill_cnt), 2);
        #3;
        reset = 1'b0;
        #1;
        chk("areset.out_valid", 32'(out_valid), 0);
        chk("areset.sum_out", 32'(sum_out), 0);
        chk("areset.peak_out", 32'(peak_out), 0);
        chk("areset.overrun", 32'(overrun), 0);
        chk("areset.fill_cnt", 32'(fill_cnt), 0);
        @(negedge clk);
        reset = 1'b1;
        step(0, 1, 16'd1, 1);
        step(0, 1, 16'd1, 1);
        step(0, 1, 16'd1, 1);
        step(0, 1, 16'd1, 1);
        chk_outputs("post_areset", 1, 4, 1, 0, 0);

        // Randomized traffic against the window model.
        model_reset();
        step(1, 0, '0, 0);
        for (int n = 0; n < 2000; n++) begin
            bit          r_clr, r_v, r_rdy;
            int unsigned r_d;
            r_clr = ($urandom_range(0, 60) == 0);
            r_v   = ($urandom_range(0, 3) != 0);
            r_rdy = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 7))
                0:       r_d = 65535;
                1:       r_d = 0;
                default: r_d = $urandom_range(0, 65535);
            endcase
            step(r_clr, r_v, (2*S)'(r_d), r_rdy);
            model_step(r_clr, r_v, r_d, r_rdy);
            chk_outputs($sformatf("rand%0d", n), m_ov, m_sum, m_pk, m_ovr, win_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
